axon_spike_decoder: RTL and testbench
=====================================

AXON_SPIKE_DECODER -- requirements
Module: axon_spike_decoder

Interface
REQ-001 SHALL have parameter NUM_AXONS, default 256, meaning the number of axons per core (a power of two, at least 2).
REQ-002 SHALL define AW = $clog2(NUM_AXONS) as the axon index width.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port tick, input, 1 bit: one-cycle global time-step pulse.
REQ-006 SHALL have port spike_wr_en, input, 1 bit: an incoming spike packet is valid this cycle.
REQ-007 SHALL have port spike_wr_axon, input, AW bits: destination axon of the incoming packet.
REQ-008 SHALL have port read_spike, input, 1 bit: pop request from the core controller.
REQ-009 SHALL have port decoder_empty, output, 1 bit, registered: high when no axon is pending in the current tick.
REQ-010 SHALL have port axon_number_out, output, AW bits, registered: the popped axon index.
REQ-011 SHALL have port axon_number_valid, output, 1 bit, registered: one-cycle pulse qualifying axon_number_out.
REQ-012 SHALL have port overrun, output, 1 bit, registered: one-cycle pulse when pending spikes are discarded at a tick.

Function
REQ-013 SHALL hold two NUM_AXONS-bit bitmaps: fill (spikes for the next tick) and drain (spikes for the current tick).
REQ-014 SHALL, on spike_wr_en, set fill[spike_wr_axon]; a duplicate write to a set bit has no further effect.
REQ-015 SHALL, on tick, load drain with the old fill (including a same-cycle write) and clear fill.
REQ-016 SHALL, on tick with drain bits still set after any same-cycle pop, discard those bits and pulse overrun the next cycle.
REQ-017 SHALL, on read_spike with drain nonzero, select the lowest set index, clear that bit, and drive axon_number_out = index with axon_number_valid = 1 the following cycle (latency 1).
REQ-018 SHALL ignore read_spike while drain is zero: axon_number_valid stays 0 and axon_number_out holds its value.
REQ-019 SHALL service read_spike on consecutive cycles, one pop per cycle, in ascending axon order.
REQ-020 SHALL, when read_spike and tick coincide, perform the pop on the pre-tick drain first, then swap.
REQ-021 SHALL compute decoder_empty from the next-state drain, so it is exact in the cycle after any pop, tick or reset.
REQ-022 SHALL leave spike_wr_en writes unaffected by reads; fill and drain are independent.

Reset
REQ-023 SHALL, while rst is high, clear both bitmaps and set decoder_empty = 1, axon_number_valid = 0, axon_number_out = 0, overrun = 0.
REQ-024 SHALL, when rst is high, override tick, spike_wr_en and read_spike in the same cycle; a reset mid-drain drops all pending spikes without pulsing overrun.

Structure
REQ-025 SHALL place AW and any shared spike-packet field widths in the core shared package.
REQ-026 SHALL use one sub-module, lowest_set_encoder (NUM_AXONS-bit vector -> AW-bit index plus any flag), for the lowest-set-bit selection.
REQ-027 SHALL be implementable in 120-400 lines of RTL with no memories beyond flops.

Verification
REQ-028 Write axons 5, 200 and 5, then tick, then read_spike three times -> valid pulses with 5 then 200; the third read gives no valid; decoder_empty = 1 after the second pop.
REQ-029 Reset, then tick with no writes -> decoder_empty stays 1 and overrun stays 0.
REQ-030 Write axon 7, tick, no reads, then write axon 9 and tick -> overrun pulses once, the drain holds only 9, and a read yields 9.
REQ-031 Set the drain to {3,4}, then assert read_spike and tick in the same cycle, with axon 10 in fill and a same-cycle write to 11 -> valid with 3, overrun pulse, and the drain becomes {10,11}.
REQ-032 Write axons 0 and NUM_AXONS-1, tick, then read_spike on back-to-back cycles -> 0 then 255 on consecutive cycles, then decoder_empty = 1.
REQ-033 Set the drain to {1,2,3}, then assert rst after the first pop -> all outputs return to reset values, no overrun pulse, and a later tick yields empty.

Source files
------------

// File: rtl/axon_spike_decoder_pkg.sv
// rtl/axon_spike_decoder_pkg.sv - shared axon-index widths for the spike decoder
// Purpose: default core geometry and the axon index width rule.
// Ports: none (package).
package axon_spike_decoder_pkg;

  localparam int DEFAULT_NUM_AXONS = 256;

  // Axon index width for a core of n axons; n is a power of two >= 2.
  function automatic int axon_aw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEFAULT_AW = axon_aw(DEFAULT_NUM_AXONS);

  // Field width of the axon address carried in an incoming spike packet.
  localparam int SPIKE_PKT_AXON_W = DEFAULT_AW;

  typedef logic [DEFAULT_AW-1:0] axon_idx_t;

endpackage

// File: rtl/axon_spike_decoder_if.sv
// rtl/axon_spike_decoder_if.sv - spike write / pop / status bundle of the decoder
// Purpose: groups the decoder's control inputs and registered outputs.
// Ports (signals):
//   tick, spike_wr_en, spike_wr_axon, read_spike : controller -> decoder
//   decoder_empty, axon_number_out,
//   axon_number_valid, overrun                   : decoder -> controller
interface axon_spike_decoder_if #(
  parameter int NUM_AXONS = axon_spike_decoder_pkg::DEFAULT_NUM_AXONS
) ();
  import axon_spike_decoder_pkg::*;

  localparam int AW = axon_aw(NUM_AXONS);

  logic          tick;
  logic          spike_wr_en;
  logic [AW-1:0] spike_wr_axon;
  logic          read_spike;
  logic          decoder_empty;
  logic [AW-1:0] axon_number_out;
  logic          axon_number_valid;
  logic          overrun;

  modport master (
    output tick, spike_wr_en, spike_wr_axon, read_spike,
    input  decoder_empty, axon_number_out, axon_number_valid, overrun
  );

  modport slave (
    input  tick, spike_wr_en, spike_wr_axon, read_spike,
    output decoder_empty, axon_number_out, axon_number_valid, overrun
  );

endinterface

// File: rtl/axon_spike_decoder_lowest_set_encoder.sv
// rtl/axon_spike_decoder_lowest_set_encoder.sv - lowest-set-bit index encoder
// Purpose: returns the index of the lowest set bit of vec.
// Ports:
//   vec   : W-bit input vector
//   idx   : index of lowest set bit (0 when vec is zero)
//   found : vec has at least one bit set
module lowest_set_encoder
  import axon_spike_decoder_pkg::*;
#(
  parameter int W = DEFAULT_NUM_AXONS
) (
  input  logic [W-1:0]         vec,
  output logic [axon_aw(W)-1:0] idx,
  output logic                 found
);

  localparam int AW = axon_aw(W);

  // Scan from the top down so the last match (lowest index) wins.
  always_comb begin
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = AW'(i);
      end
    end
  end

  assign found = |vec;

endmodule

// File: rtl/axon_spike_decoder.sv
// rtl/axon_spike_decoder.sv - double-buffered axon spike bitmap with ordered pop
// Purpose: collects spikes for the next time step in a fill bitmap and serves the
//   current step's spikes from a drain bitmap, lowest axon first.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of axon_spike_decoder_if (write/tick/pop in, status out)
module axon_spike_decoder
  import axon_spike_decoder_pkg::*;
#(
  parameter int NUM_AXONS = DEFAULT_NUM_AXONS
) (
  input  logic                 clk,
  input  logic                 rst,
  axon_spike_decoder_if.slave  bus
);

  localparam int AW = axon_aw(NUM_AXONS);

  logic [NUM_AXONS-1:0] fill_q, fill_d;
  logic [NUM_AXONS-1:0] drain_q, drain_d;
  logic                 empty_q, empty_d;
  logic [AW-1:0]        out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 overrun_q, overrun_d;

  logic [AW-1:0]        low_idx;
  logic                 low_found;
  logic                 pop;
  logic [NUM_AXONS-1:0] fill_wr;
  logic [NUM_AXONS-1:0] drain_after_pop;

  lowest_set_encoder #(.W(NUM_AXONS)) u_enc (
    .vec   (drain_q),
    .idx   (low_idx),
    .found (low_found)
  );

  always_comb begin
    pop     = bus.read_spike && low_found;

    fill_wr = fill_q;
    if (bus.spike_wr_en) begin
      fill_wr = fill_q | (NUM_AXONS'(1) << bus.spike_wr_axon);
    end

    // The pop always acts on the pre-tick drain; the swap happens afterwards.
    drain_after_pop = drain_q;
    if (pop) begin
      drain_after_pop = drain_q & ~(NUM_AXONS'(1) << low_idx);
    end

    fill_d    = fill_wr;
    drain_d   = drain_after_pop;
    overrun_d = 1'b0;
    if (bus.tick) begin
      overrun_d = |drain_after_pop;
      drain_d   = fill_wr;
      fill_d    = '0;
    end

    valid_d = pop;
    out_d   = pop ? low_idx : out_q;
    empty_d = ~|drain_d;

    if (rst) begin
      fill_d    = '0;
      drain_d   = '0;
      valid_d   = 1'b0;
      out_d     = '0;
      overrun_d = 1'b0;
      empty_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    fill_q    <= fill_d;
    drain_q   <= drain_d;
    empty_q   <= empty_d;
    out_q     <= out_d;
    valid_q   <= valid_d;
    overrun_q <= overrun_d;
  end

  assign bus.decoder_empty     = empty_q;
  assign bus.axon_number_out   = out_q;
  assign bus.axon_number_valid = valid_q;
  assign bus.overrun           = overrun_q;

endmodule

// File: tb/tb_axon_spike_decoder.sv
// tb/tb_axon_spike_decoder.sv - self-checking bench for axon_spike_decoder
module tb_axon_spike_decoder;

  localparam int N  = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  axon_spike_decoder_if #(.NUM_AXONS(N)) bus ();

  axon_spike_decoder #(.NUM_AXONS(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference: fill as a set of axons, drain as an ascending queue of axons.
  bit fill_m [N];
  int dq [$];
  int exp_out;
  bit exp_valid;
  bit exp_ovr;
  bit exp_empty;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_step(input bit tk, input bit wr, input int wa,
                            input bit rd, input bit rs);
    if (rs) begin
      foreach (fill_m[i]) fill_m[i] = 1'b0;
      dq.delete();
      exp_valid = 0;
      exp_out   = 0;
      exp_ovr   = 0;
      exp_empty = 1;
      return;
    end
    if (wr) fill_m[wa] = 1'b1;
    exp_valid = 0;
    if (rd && dq.size() > 0) begin
      exp_out   = dq.pop_front();
      exp_valid = 1;
    end
    exp_ovr = 0;
    if (tk) begin
      exp_ovr = (dq.size() > 0);
      dq.delete();
      for (int i = 0; i < N; i++) begin
        if (fill_m[i]) dq.push_back(i);
        fill_m[i] = 1'b0;
      end
    end
    exp_empty = (dq.size() == 0);
  endtask

  // One clock cycle: drive inputs, advance model, sample 1 time unit after edge.
  task automatic step(input bit tk, input bit wr, input int wa,
                      input bit rd, input bit rs);
    rst               = rs;
    bus.tick          = tk;
    bus.spike_wr_en   = wr;
    bus.spike_wr_axon = AW'(wa);
    bus.read_spike    = rd;
    model_step(tk, wr, wa, rd, rs);
    @(posedge clk);
    #1;
    check("valid",   int'(bus.axon_number_valid), int'(exp_valid));
    check("overrun", int'(bus.overrun),           int'(exp_ovr));
    check("empty",   int'(bus.decoder_empty),     int'(exp_empty));
    check("axon",    int'(bus.axon_number_out),   exp_out);
  endtask

  task automatic wr_axon(input int a); step(0, 1, a, 0, 0); endtask
  task automatic do_tick();            step(1, 0, 0, 0, 0); endtask
  task automatic do_read();            step(0, 0, 0, 1, 0); endtask

  initial begin
    exp_out = 0;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst_empty", int'(bus.decoder_empty), 1);
    check("rst_axon",  int'(bus.axon_number_out), 0);

    // Tick with nothing written.
    do_tick();
    check("t029_empty", int'(bus.decoder_empty), 1);
    check("t029_ovr",   int'(bus.overrun), 0);

    // Duplicate writes collapse; ascending pop; extra read is ignored.
    wr_axon(5); wr_axon(200); wr_axon(5); do_tick();
    do_read();
    check("t028_pop1", int'(bus.axon_number_out), 5);
    do_read();
    check("t028_pop2", int'(bus.axon_number_out), 200);
    check("t028_empty", int'(bus.decoder_empty), 1);
    do_read();
    check("t028_novalid", int'(bus.axon_number_valid), 0);
    check("t028_hold",    int'(bus.axon_number_out), 200);

    // Unread spike discarded at next tick.
    wr_axon(7); do_tick(); wr_axon(9); do_tick();
    check("t030_ovr", int'(bus.overrun), 1);
    do_read();
    check("t030_pop", int'(bus.axon_number_out), 9);
    check("t030_empty", int'(bus.decoder_empty), 1);

    // Pop, write and tick in the same cycle.
    wr_axon(3); wr_axon(4); do_tick(); wr_axon(10);
    step(1, 1, 11, 1, 0);
    check("t031_pop", int'(bus.axon_number_out), 3);
    check("t031_ovr", int'(bus.overrun), 1);
    do_read();
    check("t031_pop10", int'(bus.axon_number_out), 10);
    do_read();
    check("t031_pop11", int'(bus.axon_number_out), 11);

    // Extreme indices back to back.
    wr_axon(0); wr_axon(N - 1); do_tick();
    do_read();
    check("t032_pop0", int'(bus.axon_number_out), 0);
    do_read();
    check("t032_poplast", int'(bus.axon_number_out), N - 1);
    check("t032_empty", int'(bus.decoder_empty), 1);

    // Reset mid-drain drops everything silently.
    wr_axon(1); wr_axon(2); wr_axon(3); do_tick();
    do_read();
    step(0, 0, 0, 1, 1);
    check("t033_ovr", int'(bus.overrun), 0);
    check("t033_empty", int'(bus.decoder_empty), 1);
    check("t033_axon", int'(bus.axon_number_out), 0);
    do_tick();
    check("t033_tick_empty", int'(bus.decoder_empty), 1);
    check("t033_tick_ovr", int'(bus.overrun), 0);

    // Randomized traffic; a narrow axon range forces duplicates sometimes.
    for (int c = 0; c < 3000; c++) begin
      bit tk, wr, rd, rs;
      int wa;
      tk = ($urandom_range(0, 19) == 0);
      wr = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 199) == 0);
      wa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7)
                                       : $urandom_range(0, N - 1);
      step(tk, wr, wa, rd, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
